// File: rtl/oam_dma_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | oam_dma_engine: copies one 256-byte CPU memory page into sprite OAM    |
// | while holding the CPU stalled.                        Revision: 1.0    |
// +-----------------------------------------------------------------------+
module oam_dma_engine #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int          ADDR_W       = 16,
   parameter int          MEM_LAT      = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [7:0]        mem_rd_data,
   output logic [7:0]        oam_addr,
   output logic [7:0]        oam_data,
   output logic              oam_we,
   output logic              cpu_stall,
   output logic              busy,
   output logic              done
);

   // The READ/WRITE pairing assumes read data arrives exactly one cycle later.
   if (MEM_LAT != 1) begin : g_lat_check
      $error("oam_dma_engine supports MEM_LAT == 1 only");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] cnt_q, cnt_d;
   logic       parity_q;
   logic       done_q, done_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         page_q   <= 8'd0;
         cnt_q    <= 8'd0;
         parity_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         cnt_q    <= cnt_d;
         parity_q <= ~parity_q;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      mem_addr = '0;
      mem_re   = 1'b0;
      oam_addr = 8'd0;
      oam_data = 8'd0;
      oam_we   = 1'b0;
      busy     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
               page_d  = cpu_data;
               cnt_d   = 8'd0;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            busy    = 1'b1;
            // An odd halt cycle costs one extra alignment cycle before reads start.
            state_d = parity_q ? S_ALIGN : S_READ;
         end
         S_ALIGN: begin
            busy    = 1'b1;
            state_d = S_READ;
         end
         S_READ: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = ADDR_W'({page_q, cnt_q});
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            busy     = 1'b1;
            oam_we   = 1'b1;
            oam_addr = cnt_q;
            oam_data = mem_rd_data;
            if (cnt_q == 8'hFF) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = S_READ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cpu_stall = busy;
   assign done      = done_q;
   assign mem_we    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_oam_dma_engine: directed + randomized bench with a transfer-level   |
// | reference model of the OAM DMA copy.                  Revision: 1.0    |
// +-----------------------------------------------------------------------+
module tb_oam_dma_engine;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_data;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_rd_data;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        oam_we;
   logic        cpu_stall;
   logic        busy;
   logic        done;

   always #5 Clk = ~Clk;

   oam_dma_engine #(
      .DMA_REG_ADDR (16'h4014),
      .ADDR_W       (16),
      .MEM_LAT      (1)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .cpu_addr    (cpu_addr),
      .cpu_we      (cpu_we),
      .cpu_data    (cpu_data),
      .mem_addr    (mem_addr),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .mem_rd_data (mem_rd_data),
      .oam_addr    (oam_addr),
      .oam_data    (oam_data),
      .oam_we      (oam_we),
      .cpu_stall   (cpu_stall),
      .busy        (busy),
      .done        (done)
   );

   // Memory with one cycle of read latency
   logic [7:0] mem [0:65535];
   always @(posedge Clk) mem_rd_data <= mem[mem_addr];

   // Cycles since reset released; parity of a cycle is the low bit
   int pcnt = 0;
   always @(posedge Clk) pcnt <= Reset ? 0 : pcnt + 1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard filled by the negedge monitor
   logic [15:0] wq[$];
   logic [15:0] rq[$];
   int          stall_n, gap_n, busy_n, done_n;
   int          mcyc = 0;
   int          last_we_cyc, done_cyc;
   logic [15:0] addr_at_done;

   task automatic clear_sb();
      wq.delete();
      rq.delete();
      stall_n      = 0;
      gap_n        = 0;
      busy_n       = 0;
      done_n       = 0;
      last_we_cyc  = -1;
      done_cyc     = -1;
      addr_at_done = 16'hDEAD;
   endtask

   always @(negedge Clk) begin
      mcyc++;
      chk("mem_we_low", {31'd0, mem_we}, 32'd0);
      if (busy === 1'b0) chk("idle_quiet", {29'd0, mem_re, oam_we, cpu_stall}, 32'd0);
      if (cpu_stall) stall_n++;
      if (cpu_stall && !mem_re && !oam_we) gap_n++;
      if (busy) busy_n++;
      if (mem_re) rq.push_back(mem_addr);
      if (oam_we) begin
         wq.push_back({oam_addr, oam_data});
         last_we_cyc = mcyc;
      end
      if (done) begin
         done_n++;
         done_cyc     = mcyc;
         addr_at_done = mem_addr;
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
      chk({pfx, "_mem_re"}, {31'd0, mem_re}, 32'd0);
      chk({pfx, "_oam_addr"}, {24'd0, oam_addr}, 32'd0);
      chk({pfx, "_oam_data"}, {24'd0, oam_data}, 32'd0);
      chk({pfx, "_oam_we"}, {31'd0, oam_we}, 32'd0);
      chk({pfx, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
      chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
      chk({pfx, "_done"}, {31'd0, done}, 32'd0);
   endtask

   // Trigger so that the following (halt) cycle has the requested parity
   task automatic trigger(input logic [7:0] page, input bit par);
      while (pcnt[0] == par) step();
      clear_sb();
      cpu_addr = 16'h4014;
      cpu_data = page;
      cpu_we   = 1'b1;
      step();
      cpu_we   = 1'b0;
      cpu_addr = 16'($urandom);
      cpu_data = 8'($urandom);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_n > 0) break;
         step();
      end
      chk("done_seen", {31'd0, done_n > 0}, 32'd1);
   endtask

   // Reference: a full copy of page p stalls 513 (+1 if odd halt) cycles,
   // reads p*256+k in order and writes OAM[k] = mem[p*256+k].
   task automatic check_xfer(input logic [7:0] page, input bit par);
      int base;
      base = int'(page) * 256;
      repeat (3) step();
      chk("stall_len", stall_n, 513 + int'(par));
      chk("halt_align_cycles", gap_n, 1 + int'(par));
      chk("oam_we_count", wq.size(), 256);
      chk("mem_re_count", rq.size(), 256);
      for (int k = 0; k < 256; k++) begin
         if (k < wq.size()) begin
            chk("oam_addr", {24'd0, wq[k][15:8]}, k);
            chk("oam_data", {24'd0, wq[k][7:0]}, {24'd0, mem[base + k]});
         end
         if (k < rq.size()) chk("mem_addr", {16'd0, rq[k]}, base + k);
      end
      chk("done_count", done_n, 1);
      chk("done_after_last_we", done_cyc, last_we_cyc + 1);
      chk("mem_addr_at_done", {16'd0, addr_at_done}, 32'd0);
   endtask

   task automatic full_xfer(input logic [7:0] page, input bit par);
      trigger(page, par);
      wait_done(800);
      check_xfer(page, par);
   endtask

   initial begin
      bit   par;
      logic found;

      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int k = 0; k < 256; k++) mem[16'h0200 + k] = 8'(k) ^ 8'h5A;

      Reset    = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'd0;
      cpu_data = 8'd0;
      clear_sb();
      repeat (3) step();
      chk_outputs_zero("reset");
      Reset = 1'b0;
      step();

      // Basic copies, even and odd halt parity
      full_xfer(8'h02, 1'b0);
      full_xfer(8'h02, 1'b1);

      // Neighbouring addresses and a read of the trigger address do nothing
      clear_sb();
      cpu_we = 1'b1; cpu_addr = 16'h4013; cpu_data = 8'h02; step();
      cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_data = 8'h02; step();
      cpu_we = 1'b0; cpu_addr = 16'h4014; cpu_data = 8'h02; step();
      cpu_addr = 16'h0000;
      repeat (10) step();
      chk("nontrigger_busy", busy_n, 0);
      chk("nontrigger_reads", rq.size(), 0);
      chk("nontrigger_writes", wq.size(), 0);

      // Second trigger during a transfer is ignored
      par = 1'($urandom);
      trigger(8'h03, par);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (oam_we && oam_addr == 8'd10) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("reached_cnt10", {31'd0, found}, 32'd1);
      cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data = 8'h07;
      step();
      cpu_we = 1'b0; cpu_addr = 16'h0000;
      wait_done(800);
      check_xfer(8'h03, par);

      // Reset in the middle of a transfer, then a trigger held during reset
      trigger(8'h02, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (oam_we && oam_addr == 8'd100) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("reached_cnt100", {31'd0, found}, 32'd1);
      Reset = 1'b1;
      step();
      chk_outputs_zero("midreset");
      clear_sb();
      cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data = 8'h02;
      step();
      Reset  = 1'b0;
      cpu_we = 1'b0; cpu_addr = 16'h0000;
      repeat (20) step();
      chk("post_reset_writes", wq.size(), 0);
      chk("post_reset_done", done_n, 0);
      chk("reset_trigger_dropped", busy_n, 0);
      full_xfer(8'h02, 1'($urandom));

      // Top page
      full_xfer(8'hFF, 1'($urandom));

      // Random pages and parities
      for (int t = 0; t < 3; t++) full_xfer(8'($urandom), 1'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
